// File: rtl/gate_truth_table_checker_pkg.sv
// gate_check_pkg: shared FSM state type and wait-counter sizing for the gate checker
package gate_check_pkg;
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_CHECK, S_FINISH} state_t;
  function automatic int cnt_w(input int settle);
    return $clog2(settle + 1);
  endfunction
endpackage

// File: rtl/gate_truth_table_checker_settle_timer.sv
// settle_timer: loadable down-counter, expire asserted while the count is 1
module settle_timer #(
  parameter int W    = 1,
  parameter int LOAD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expire
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (load) cnt <= W'(LOAD);
    else if (en) cnt <= cnt - 1'b1;
  assign expire = cnt == W'(1);
endmodule

// File: rtl/gate_truth_table_checker.sv
// gate_truth_table_checker: sweeps all input vectors of an N-input gate and checks its output against a truth table
module gate_truth_table_checker
  import gate_check_pkg::*;
#(
  parameter int                 N_IN   = 2,
  parameter logic [2**N_IN-1:0] TRUTH  = 4'b1000,
  parameter int                 SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] vec,
  input  logic            dut_o,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            first_fail_valid,
  output logic [N_IN-1:0] first_fail_vec
);
  localparam int CW = cnt_w(SETTLE);
  state_t state, nxt;
  logic accept, last, miss, load, expire;
  assign accept = state == S_IDLE && start;
  assign last   = vec == {N_IN{1'b1}};
  assign miss   = state == S_CHECK && dut_o != TRUTH[vec];
  assign load   = accept || (state == S_CHECK && !last);
  settle_timer #(.W(CW), .LOAD(SETTLE)) u_timer (
    .clk(clk),
    .rst(rst),
    .load(load),
    .en(state == S_SETTLE),
    .expire(expire)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= nxt;
  always_comb
    nxt = state == S_IDLE   ? (start ? S_SETTLE : S_IDLE) :
          state == S_SETTLE ? (expire ? S_CHECK : S_SETTLE) :
          state == S_CHECK  ? (last ? S_FINISH : S_SETTLE) : S_IDLE;
  always_comb begin
    busy = state == S_SETTLE || state == S_CHECK;
    done = state == S_FINISH;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      vec              <= '0;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (accept) begin
      vec              <= '0;
      err_count        <= '0;
      pass             <= 1'b0;
      first_fail_valid <= 1'b0;
      first_fail_vec   <= '0;
    end else if (state == S_CHECK) begin
      if (miss) err_count <= err_count + 1'b1;
      if (miss && !first_fail_valid) begin
        first_fail_vec   <= vec;
        first_fail_valid <= 1'b1;
      end
      if (last) pass <= err_count == '0 && !miss;
      else vec <= vec + 1'b1;
    end
endmodule

// File: tb/tb_gate_truth_table_checker.sv
// tb_gate_truth_table_checker: directed and randomized runs of two checker instances against a truth-table model
module tb_gate_truth_table_checker;
  localparam int O_VEC = 0, O_BUSY = 1, O_DONE = 2, O_PASS = 3, O_ERR = 4, O_FFV = 5, O_FFVEC = 6;
  logic clk = 1'b0, rst = 1'b0, a_start = 1'b0, b_start = 1'b0;
  logic [1:0] a_vec, a_ffvec;
  logic [2:0] b_vec, b_ffvec, a_err;
  logic [3:0] b_err;
  logic a_dut_o, a_busy, a_done, a_pass, a_ffv;
  logic b_dut_o, b_busy, b_done, b_pass, b_ffv;
  int a_mode = 0, b_mode = 0;
  logic [7:0] a_flip = '0, b_flip = '0;
  int vectors = 0, miscompares = 0;

  always #5 clk = ~clk;

  // mode 0: AND, 1: OR, 2: stuck at 0, 3: ideal AND with per-vector flipped outputs
  function automatic logic gate(input int v, input int n, input int mode, input logic [7:0] flip);
    logic all_ones;
    all_ones = v == (1 << n) - 1;
    return mode == 0 ? all_ones : mode == 1 ? v != 0 : mode == 2 ? 1'b0 : all_ones ^ flip[v];
  endfunction

  assign a_dut_o = gate(int'(a_vec), 2, a_mode, a_flip);
  assign b_dut_o = gate(int'(b_vec), 3, b_mode, b_flip);

  gate_truth_table_checker u_a (
    .clk(clk), .rst(rst), .start(a_start), .vec(a_vec), .dut_o(a_dut_o),
    .busy(a_busy), .done(a_done), .pass(a_pass), .err_count(a_err),
    .first_fail_valid(a_ffv), .first_fail_vec(a_ffvec)
  );
  gate_truth_table_checker #(.N_IN(3), .TRUTH(8'h80), .SETTLE(3)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .vec(b_vec), .dut_o(b_dut_o),
    .busy(b_busy), .done(b_done), .pass(b_pass), .err_count(b_err),
    .first_fail_valid(b_ffv), .first_fail_vec(b_ffvec)
  );

  function automatic logic [31:0] o(input bit sel, input int k);
    case (k)
      O_VEC:   return sel ? 32'(b_vec) : 32'(a_vec);
      O_BUSY:  return sel ? 32'(b_busy) : 32'(a_busy);
      O_DONE:  return sel ? 32'(b_done) : 32'(a_done);
      O_PASS:  return sel ? 32'(b_pass) : 32'(a_pass);
      O_ERR:   return sel ? 32'(b_err) : 32'(a_err);
      O_FFV:   return sel ? 32'(b_ffv) : 32'(a_ffv);
      default: return sel ? 32'(b_ffvec) : 32'(a_ffvec);
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) b_start = v;
    else a_start = v;
  endtask

  task automatic chk_reset(input bit sel, input string tag);
    chk({tag, ":vec"}, o(sel, O_VEC), 0);
    chk({tag, ":busy"}, o(sel, O_BUSY), 0);
    chk({tag, ":done"}, o(sel, O_DONE), 0);
    chk({tag, ":pass"}, o(sel, O_PASS), 0);
    chk({tag, ":err"}, o(sel, O_ERR), 0);
    chk({tag, ":ffv"}, o(sel, O_FFV), 0);
    chk({tag, ":ffvec"}, o(sel, O_FFVEC), 0);
  endtask

  // Called at a falling edge; start is accepted on the next rising edge
  task automatic run(input bit sel, input int mode, input logic [7:0] flip,
                     input int pulse_at, input bit hold, input string tag);
    int n, s, nv, lat, exp_err, exp_first;
    bit exp_fail;
    n = sel ? 3 : 2;
    s = sel ? 3 : 1;
    nv = 1 << n;
    lat = nv * (s + 1);
    exp_err = 0;
    exp_first = 0;
    exp_fail = 0;
    for (int v = 0; v < nv; v++)
      if (gate(v, n, mode, flip) != (v == nv - 1)) begin
        if (!exp_fail) exp_first = v;
        exp_fail = 1;
        exp_err++;
      end
    if (sel) begin b_mode = mode; b_flip = flip; end
    else begin a_mode = mode; a_flip = flip; end
    set_start(sel, 1'b1);
    @(posedge clk);
    @(negedge clk);
    for (int e = 0; e < lat; e++) begin
      set_start(sel, hold || e == pulse_at);
      chk({tag, ":vec_hold"}, o(sel, O_VEC), 32'(e / (s + 1)));
      chk({tag, ":busy_run"}, o(sel, O_BUSY), 1);
      chk({tag, ":done_early"}, o(sel, O_DONE), 0);
      @(negedge clk);
    end
    chk({tag, ":done"}, o(sel, O_DONE), 1);
    chk({tag, ":busy_fin"}, o(sel, O_BUSY), 0);
    chk({tag, ":err"}, o(sel, O_ERR), 32'(exp_err));
    chk({tag, ":ffv"}, o(sel, O_FFV), 32'(exp_fail));
    chk({tag, ":ffvec"}, o(sel, O_FFVEC), 32'(exp_first));
    chk({tag, ":pass"}, o(sel, O_PASS), 32'(!exp_fail));
    chk({tag, ":vec_last"}, o(sel, O_VEC), 32'(nv - 1));
    @(negedge clk);
    chk({tag, ":done_pulse"}, o(sel, O_DONE), 0);
    chk({tag, ":idle"}, o(sel, O_BUSY), 0);
    if (hold) begin
      @(negedge clk);
      set_start(sel, 1'b0);
      chk({tag, ":rerun_busy"}, o(sel, O_BUSY), 1);
      chk({tag, ":rerun_vec"}, o(sel, O_VEC), 0);
      chk({tag, ":rerun_err"}, o(sel, O_ERR), 0);
      chk({tag, ":rerun_pass"}, o(sel, O_PASS), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset(0, "reset_a");
    chk_reset(1, "reset_b");
    rst = 1'b1;
    @(negedge clk);
    run(0, 0, 8'h00, -1, 0, "and");
    run(0, 1, 8'h00, -1, 0, "or_fault");
    run(0, 0, 8'h00, 4, 0, "start_ignored");
    run(0, 0, 8'h00, -1, 1, "start_held");
    begin
      int i;
      for (i = 0; i < 64 && !a_done; i++) @(negedge clk);
      chk("held:second_done", 32'(a_done), 1);
      chk("held:second_pass", 32'(a_pass), 1);
      @(negedge clk);
    end
    run(1, 0, 8'h00, -1, 0, "n3_and");
    a_mode = 1;
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort:vec_before", 32'(a_vec), 2);
    chk("abort:err_before", 32'(a_err), 1);
    #2 rst = 1'b0;
    #1 chk_reset(0, "abort_async");
    repeat (2) begin
      @(negedge clk);
      chk("abort:no_done", 32'(a_done), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    run(0, 0, 8'h00, -1, 0, "after_abort");
    run(0, 2, 8'h00, -1, 0, "stuck0");
    repeat (4) run(0, 3, 8'($urandom_range(0, 15)), -1, 0, "rand_a");
    repeat (2) run(1, 3, 8'($urandom), -1, 0, "rand_b");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
